// File: rtl/spi_master_core.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_core
// Description : Single-clock SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//               A one-word holding register sits between the host byte
//               stream (di_req/wren/wr_ack) and the shift engine. Words
//               written while a word is shifting are chained back-to-back
//               with chip select held low. Chip select is released when the
//               holding register is empty at the end of a word.
//               Optional build macro SPI_LOOPBACK_EN: the receive shifter
//               takes the internal MOSI bit instead of spi_miso_i, so do_o
//               echoes the transmitted word. External pins are unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_core #(
    parameter int N       = 8,
    parameter int SCK_DIV = 2
) (
    input  logic         pclk_i,
    input  logic         rst_i,
    output logic         spi_ssel_o,
    output logic         spi_sck_o,
    output logic         spi_mosi_o,
    input  logic         spi_miso_i,
    output logic         di_req_o,
    input  logic [N-1:0] di_i,
    input  logic         wren_i,
    output logic         wr_ack_o,
    output logic         do_valid_o,
    output logic [N-1:0] do_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;

    localparam int CNT_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;       // cycles spent in current SCK phase
    logic [BIT_W-1:0] bit_q,      bit_d;       // bits completed in current word
    logic             sck_q,      sck_d;
    logic             ssel_q,     ssel_d;
    logic [N-1:0]     tx_q,       tx_d;        // MSB is the bit on the wire
    logic [N-1:0]     rx_q,       rx_d;
    logic [N-1:0]     do_q,       do_d;
    logic             do_valid_q, do_valid_d;
    logic             di_req_q,   di_req_d;
    logic             wr_ack_q,   wr_ack_d;
    logic [N-1:0]     hold_q,     hold_d;
    logic             full_q,     full_d;
    logic             init_q,     init_d;      // high only until the first edge after reset

    logic             w_load;                  // move holding register into the shifter
    logic             w_rx_bit;

    // ------------------------------------------------------------------
    // Receive bit source
    // ------------------------------------------------------------------
`ifdef SPI_LOOPBACK_EN
    assign w_rx_bit = tx_q[N-1];
`else
    assign w_rx_bit = spi_miso_i;
`endif

    // Next-state logic: SCK sequencing, word chaining and holding register
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sck_d      = sck_q;
        ssel_d     = ssel_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        do_d       = do_q;
        hold_d     = hold_q;
        full_d     = full_q;
        do_valid_d = 1'b0;
        wr_ack_d   = 1'b0;
        init_d     = 1'b0;
        // The very first cycle out of reset announces an empty holding register.
        di_req_d   = init_q;
        w_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (full_q) begin
                    w_load  = 1'b1;
                    ssel_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        // Rising edge: slave data is stable, capture it.
                        sck_d = 1'b1;
                        rx_d  = {rx_q[N-2:0], w_rx_bit};
                    end else begin
                        // Falling edge: advance MOSI to the next bit.
                        sck_d = 1'b0;
                        tx_d  = {tx_q[N-2:0], 1'b0};
                        if (bit_q == BIT_LAST) begin
                            bit_d      = '0;
                            do_d       = rx_q;
                            do_valid_d = 1'b1;
                            // Chain the next word without an SCK gap if one is waiting.
                            if (full_q) begin
                                w_load = 1'b1;
                            end else begin
                                state_d = ST_END;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_END: begin
                // Hold SCK low for one half-period before releasing chip select.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    ssel_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ssel_d  = 1'b1;
                sck_d   = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Loading and capturing are mutually exclusive: load needs a full
        // holding register, capture needs an empty one. Capture is held off
        // during the post-reset request cycle so ack and request never overlap.
        if (w_load) begin
            tx_d     = hold_q;
            full_d   = 1'b0;
            di_req_d = 1'b1;
            cnt_d    = '0;
            bit_d    = '0;
            sck_d    = 1'b0;
        end else if (!full_q && wren_i && !init_q) begin
            hold_d   = di_i;
            full_d   = 1'b1;
            wr_ack_d = 1'b1;
        end
    end

    // State registers with asynchronous reset; reset aborts any word in flight
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            tx_q       <= '0;
            rx_q       <= '0;
            do_q       <= '0;
            do_valid_q <= 1'b0;
            di_req_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            init_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sck_q      <= sck_d;
            ssel_q     <= ssel_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            do_q       <= do_d;
            do_valid_q <= do_valid_d;
            di_req_q   <= di_req_d;
            wr_ack_q   <= wr_ack_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            init_q     <= init_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spi_ssel_o = ssel_q;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = tx_q[N-1];
    assign di_req_o   = di_req_q;
    assign wr_ack_o   = wr_ack_q;
    assign do_valid_o = do_valid_q;
    assign do_o       = do_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_core
// Description : Self-checking bench for spi_master_core. A sampling monitor
//               plays an SPI slave (one word per session slot) and collects
//               MOSI words, received words and handshake pulse counts; each
//               test task compares them with expectations derived from the
//               words it wrote and the words the slave returned.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_core;

    localparam int N        = 8;
    localparam int SCK_DIV  = 2;
    localparam int WORD_CYC = 2 * N * SCK_DIV;

    logic         pclk_i = 1'b0;
    logic         rst_i  = 1'b1;
    logic         spi_ssel_o;
    logic         spi_sck_o;
    logic         spi_mosi_o;
    logic         spi_miso_i = 1'b0;
    logic         di_req_o;
    logic [N-1:0] di_i   = '0;
    logic         wren_i = 1'b0;
    logic         wr_ack_o;
    logic         do_valid_o;
    logic [N-1:0] do_o;

    spi_master_core #(.N(N), .SCK_DIV(SCK_DIV)) dut (
        .pclk_i     (pclk_i),
        .rst_i      (rst_i),
        .spi_ssel_o (spi_ssel_o),
        .spi_sck_o  (spi_sck_o),
        .spi_mosi_o (spi_mosi_o),
        .spi_miso_i (spi_miso_i),
        .di_req_o   (di_req_o),
        .di_i       (di_i),
        .wren_i     (wren_i),
        .wr_ack_o   (wr_ack_o),
        .do_valid_o (do_valid_o),
        .do_o       (do_o)
    );

    always #5 pclk_i = ~pclk_i;

    int checks   = 0;
    int failures = 0;

    // Slave data per word slot of a chip-select session
    logic [N-1:0] slave_words [0:63];
    logic         miso_force0 = 1'b0;
    logic [N-1:0] stim_q [$];

    // Monitor results
    int           ssel_low_cyc, ssel_rises, sck_pulses, hi_run, hi_min, hi_max;
    int           ack_cnt, req_cnt, dv_cnt, overlap_cnt, sess_rises, mbits;
    logic [N-1:0] mword;
    logic [N-1:0] mosi_words [$];
    logic [N-1:0] rx_words [$];
    logic         prev_sck = 1'b0;
    logic         prev_ssel = 1'b1;

    task automatic clear_mon();
        ssel_low_cyc = 0; ssel_rises = 0; sck_pulses = 0;
        hi_run = 0; hi_min = 1000; hi_max = 0;
        ack_cnt = 0; req_cnt = 0; dv_cnt = 0; overlap_cnt = 0;
        mosi_words.delete();
        rx_words.delete();
    endtask

    // Sample one time unit after each rising edge; also acts as the slave
    always begin
        int           slot;
        int           bitpos;
        logic [N-1:0] sw;
        @(posedge pclk_i);
        #1;
        if (rst_i) begin
            mbits = 0; sess_rises = 0; hi_run = 0;
            prev_sck = 1'b0; prev_ssel = 1'b1;
        end else begin
            if (wr_ack_o) ack_cnt++;
            if (di_req_o) req_cnt++;
            if (wr_ack_o && di_req_o) overlap_cnt++;
            if (do_valid_o) begin
                dv_cnt++;
                rx_words.push_back(do_o);
            end
            if (!spi_ssel_o) ssel_low_cyc++;
            if (spi_ssel_o && !prev_ssel) ssel_rises++;
            if (spi_sck_o) hi_run++;
            if (spi_sck_o && !prev_sck) begin
                sck_pulses++;
                sess_rises++;
                mword = {mword[N-2:0], spi_mosi_o};
                mbits++;
                if (mbits == N) begin
                    mosi_words.push_back(mword);
                    mbits = 0;
                end
            end
            if (!spi_sck_o && prev_sck) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
            end
            if (spi_ssel_o) begin
                sess_rises = 0;
                mbits = 0;
            end
            prev_sck  = spi_sck_o;
            prev_ssel = spi_ssel_o;
        end
        slot   = (sess_rises / N) % 64;
        bitpos = N - 1 - (sess_rises % N);
        sw     = slave_words[slot];
        spi_miso_i = miso_force0 ? 1'b0 : sw[bitpos];
    end

    // Expected received word for slot k given the word sent in that slot
    function automatic logic [N-1:0] exp_rx(input int k, input logic [N-1:0] sent);
`ifdef SPI_LOOPBACK_EN
        exp_rx = sent;
`else
        exp_rx = slave_words[k];
`endif
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; wren_i = 1'b0;
        repeat (3) @(negedge pclk_i);
        checks++;
        if (spi_ssel_o !== 1'b1) begin
            failures++; $display("FAIL reset_ssel: got %b expected 1", spi_ssel_o);
        end
        checks++;
        if (spi_sck_o !== 1'b0) begin
            failures++; $display("FAIL reset_sck: got %b expected 0", spi_sck_o);
        end
        checks++;
        if ({spi_mosi_o, di_req_o, wr_ack_o, do_valid_o, do_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: mosi=%b req=%b ack=%b dv=%b do=%h expected all 0",
                     spi_mosi_o, di_req_o, wr_ack_o, do_valid_o, do_o);
        end
        clear_mon();
        rst_i = 1'b0;
        @(posedge pclk_i);
        #2;
        checks++;
        if (di_req_o !== 1'b1) begin
            failures++; $display("FAIL reset_first_req: got %b expected 1", di_req_o);
        end
        repeat (6) @(negedge pclk_i);
        checks++;
        if (req_cnt !== 1) begin
            failures++; $display("FAIL reset_req_count: got %0d expected 1", req_cnt);
        end
        checks++;
        if (spi_ssel_o !== 1'b1 || spi_sck_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_pins: ssel=%b sck=%b expected ssel=1 sck=0", spi_ssel_o, spi_sck_o);
        end
    endtask

    task automatic test_single(input logic [N-1:0] tx, input logic [N-1:0] slv);
        int           cyc;
        logic [N-1:0] got;
        logic [N-1:0] want;
        slave_words[0] = slv;
        clear_mon();
        @(negedge pclk_i);
        di_i = tx; wren_i = 1'b1;
        @(negedge pclk_i);
        wren_i = 1'b0;
        for (cyc = 0; cyc < 200; cyc++) begin
            @(negedge pclk_i);
            if (ssel_rises > 0) break;
        end
        checks++;
        if (ssel_rises == 0) begin
            failures++; $display("FAIL single_timeout: ssel never returned high for word %h", tx);
        end
        repeat (3) @(negedge pclk_i);
        want = exp_rx(0, tx);
        checks++;
        if (ack_cnt !== 1 || req_cnt !== 1 || overlap_cnt !== 0) begin
            failures++;
            $display("FAIL single_handshake: ack=%0d req=%0d overlap=%0d expected 1 1 0",
                     ack_cnt, req_cnt, overlap_cnt);
        end
        checks++;
        if (sck_pulses !== N || hi_min !== SCK_DIV || hi_max !== SCK_DIV) begin
            failures++;
            $display("FAIL single_sck: pulses=%0d high=%0d..%0d expected %0d pulses of %0d",
                     sck_pulses, hi_min, hi_max, N, SCK_DIV);
        end
        checks++;
        if (ssel_low_cyc !== WORD_CYC + SCK_DIV) begin
            failures++;
            $display("FAIL single_ssel_low: got %0d cycles expected %0d", ssel_low_cyc, WORD_CYC + SCK_DIV);
        end
        got = (mosi_words.size() > 0) ? mosi_words[0] : 'x;
        checks++;
        if (mosi_words.size() !== 1 || got !== tx) begin
            failures++;
            $display("FAIL single_mosi: got %h (%0d words) expected %h", got, mosi_words.size(), tx);
        end
        got = (rx_words.size() > 0) ? rx_words[0] : 'x;
        checks++;
        if (dv_cnt !== 1 || got !== want || do_o !== want) begin
            failures++;
            $display("FAIL single_rx: dv=%0d pulse_data=%h do=%h expected 1 pulse of %h",
                     dv_cnt, got, do_o, want);
        end
    endtask

    // Streams stim_q with wren held high, advancing di_i after each ack
    task automatic test_stream();
        int           n;
        int           idx;
        int           cyc;
        logic [N-1:0] got;
        n = stim_q.size();
        for (int k = 0; k < n; k++) slave_words[k] = N'($urandom);
        clear_mon();
        idx = 0;
        @(negedge pclk_i);
        di_i = stim_q[0]; wren_i = 1'b1;
        for (cyc = 0; cyc < 2000 && idx < n; cyc++) begin
            @(negedge pclk_i);
            if (wr_ack_o) begin
                idx++;
                if (idx == n) wren_i = 1'b0;
                else di_i = stim_q[idx];
            end
        end
        wren_i = 1'b0;
        for (cyc = 0; cyc < 2000; cyc++) begin
            @(negedge pclk_i);
            if (ssel_rises > 0) break;
        end
        checks++;
        if (idx != n || ssel_rises == 0) begin
            failures++; $display("FAIL stream_timeout: acked %0d of %0d words", idx, n);
        end
        repeat (3) @(negedge pclk_i);
        checks++;
        if (ack_cnt !== n || dv_cnt !== n || overlap_cnt !== 0) begin
            failures++;
            $display("FAIL stream_handshake: ack=%0d dv=%0d overlap=%0d expected %0d %0d 0",
                     ack_cnt, dv_cnt, overlap_cnt, n, n);
        end
        checks++;
        if (ssel_rises !== 1 || ssel_low_cyc !== n * WORD_CYC + SCK_DIV || sck_pulses !== n * N) begin
            failures++;
            $display("FAIL stream_continuous: ssel_rises=%0d low=%0d pulses=%0d expected 1 %0d %0d",
                     ssel_rises, ssel_low_cyc, sck_pulses, n * WORD_CYC + SCK_DIV, n * N);
        end
        for (int k = 0; k < n; k++) begin
            got = (k < mosi_words.size()) ? mosi_words[k] : 'x;
            checks++;
            if (got !== stim_q[k]) begin
                failures++; $display("FAIL stream_mosi[%0d]: got %h expected %h", k, got, stim_q[k]);
            end
            got = (k < rx_words.size()) ? rx_words[k] : 'x;
            checks++;
            if (got !== exp_rx(k, stim_q[k])) begin
                failures++;
                $display("FAIL stream_rx[%0d]: got %h expected %h", k, got, exp_rx(k, stim_q[k]));
            end
        end
    endtask

    task automatic test_full_ignore();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] c;
        logic [N-1:0] got0;
        logic [N-1:0] got1;
        int           cyc;
        a = N'($urandom); b = N'($urandom); c = ~b;
        slave_words[0] = N'($urandom); slave_words[1] = N'($urandom);
        clear_mon();
        @(negedge pclk_i);
        di_i = a; wren_i = 1'b1;
        @(negedge pclk_i);
        wren_i = 1'b0;
        for (cyc = 0; cyc < 50 && di_req_o !== 1'b1; cyc++) @(negedge pclk_i);
        di_i = b; wren_i = 1'b1;
        @(negedge pclk_i);
        di_i = c;
        repeat (3) @(negedge pclk_i);
        wren_i = 1'b0;
        for (cyc = 0; cyc < 300; cyc++) begin
            @(negedge pclk_i);
            if (ssel_rises > 0) break;
        end
        repeat (3) @(negedge pclk_i);
        checks++;
        if (ack_cnt !== 2 || dv_cnt !== 2 || ssel_rises !== 1) begin
            failures++;
            $display("FAIL full_ignore_counts: ack=%0d dv=%0d ssel_rises=%0d expected 2 2 1",
                     ack_cnt, dv_cnt, ssel_rises);
        end
        got0 = (mosi_words.size() > 0) ? mosi_words[0] : 'x;
        got1 = (mosi_words.size() > 1) ? mosi_words[1] : 'x;
        checks++;
        if (mosi_words.size() !== 2 || got0 !== a || got1 !== b) begin
            failures++;
            $display("FAIL full_ignore_mosi: got %h %h (%0d words) expected %h %h",
                     got0, got1, mosi_words.size(), a, b);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        slave_words[0] = N'($urandom);
        clear_mon();
        @(negedge pclk_i);
        di_i = N'($urandom); wren_i = 1'b1;
        @(negedge pclk_i);
        wren_i = 1'b0;
        for (cyc = 0; cyc < 100 && sck_pulses < 3; cyc++) @(negedge pclk_i);
        checks++;
        if (sck_pulses < 3) begin
            failures++; $display("FAIL reset_mid_timeout: got %0d sck pulses expected 3", sck_pulses);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (spi_ssel_o !== 1'b1 || spi_sck_o !== 1'b0 || do_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_pins: ssel=%b sck=%b dv=%b expected 1 0 0",
                     spi_ssel_o, spi_sck_o, do_valid_o);
        end
        repeat (3) @(negedge pclk_i);
        checks++;
        if (dv_cnt !== 0 || do_o !== '0) begin
            failures++; $display("FAIL reset_mid_abort: dv=%0d do=%h expected 0 00", dv_cnt, do_o);
        end
        rst_i = 1'b0;
        repeat (3) @(negedge pclk_i);
        test_single(N'($urandom), N'($urandom));
    endtask

`ifdef SPI_LOOPBACK_EN
    task automatic test_loopback();
        miso_force0 = 1'b1;
        test_single(8'h5A, 8'h00);
        miso_force0 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single(8'h89, 8'hA5);
        for (int r = 0; r < 3; r++) test_single(N'($urandom), N'($urandom));
        stim_q = '{8'h89, 8'hA4, 8'h23, 8'h00};
        test_stream();
        stim_q.delete();
        for (int r = 0; r < 6; r++) stim_q.push_back(N'($urandom));
        test_stream();
        test_full_ignore();
        test_reset_mid();
`ifdef SPI_LOOPBACK_EN
        test_loopback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
